// File: rtl/decoder_scan_nx.sv
// Registered N-to-M line decoder with direct-decode and auto-scan (strobed row/digit select) modes.
// Latency: one cycle from a sampled sel_valid/mode change to dec_out/code_out/out_valid.
// Backpressure: none; en=0 freezes all state and suppresses the wrap/range_err pulses.
module decoder_scan_nx #(
  parameter int SEL_W      = 2,
  parameter int NUM_OUT    = 4,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               mode_i,
  input  logic [SEL_W-1:0]   sel_in_i,
  input  logic               sel_valid_i,
  output logic [NUM_OUT-1:0] dec_out_o,
  output logic [SEL_W-1:0]   code_out_o,
  output logic               out_valid_o,
  output logic               wrap_o,
  output logic               range_err_o
);

  // Dwell counter needs at least one bit even when every code is held a single cycle.
  localparam int               DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] CODE_LAST  = SEL_W'(NUM_OUT - 1);
  // One extra bit so NUM_OUT == 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0]   NUM_OUT_X  = (SEL_W + 1)'(NUM_OUT);
  localparam logic [NUM_OUT-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {NUM_OUT{1'b1}} : {NUM_OUT{1'b0}};

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t             state_q, state_d;
  logic [NUM_OUT-1:0] dec_q, dec_d;
  logic [SEL_W-1:0]   code_q, code_d;
  logic               vld_q, vld_d;
  logic               wrap_q, wrap_d;
  logic               rerr_q, rerr_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;

  // One-hot line pattern for a code, with output polarity applied.
  function automatic logic [NUM_OUT-1:0] line_of(input logic [SEL_W-1:0] c);
    logic [NUM_OUT-1:0] oh;
    for (int i = 0; i < NUM_OUT; i++) begin
      oh[i] = (c == SEL_W'(i));
    end
    return (ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  // Next-state and next-output logic; everything holds unless an enabled cycle changes it.
  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    code_d  = code_q;
    vld_d   = vld_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    rerr_d  = 1'b0;
    if (en_i) begin
      case (state_q)
        IDLE:    state_d = mode_i ? SCAN : DIRECT;
        DIRECT:  if (mode_i)  state_d = SCAN;
        SCAN:    if (!mode_i) state_d = DIRECT;
        default: state_d = IDLE;
      endcase

      if (state_d == SCAN && state_q != SCAN) begin
        // Scan always restarts at code 0 with a fresh dwell.
        code_d  = '0;
        dec_d   = line_of('0);
        vld_d   = 1'b1;
        dwell_d = '0;
      end else if (state_d == SCAN) begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (code_q == CODE_LAST) begin
            code_d = '0;
            wrap_d = 1'b1;
          end else begin
            code_d = code_q + SEL_W'(1);
          end
          dec_d = line_of(code_d);
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end else if (state_d == DIRECT && sel_valid_i) begin
        if ({1'b0, sel_in_i} < NUM_OUT_X) begin
          code_d = sel_in_i;
          dec_d  = line_of(sel_in_i);
          vld_d  = 1'b1;
        end else begin
          // Illegal code: blank the lines, keep the last legal code for reference.
          dec_d  = INACTIVE;
          vld_d  = 1'b0;
          rerr_d = 1'b1;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      dec_q   <= INACTIVE;
      code_q  <= '0;
      vld_q   <= 1'b0;
      wrap_q  <= 1'b0;
      rerr_q  <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      code_q  <= code_d;
      vld_q   <= vld_d;
      wrap_q  <= wrap_d;
      rerr_q  <= rerr_d;
      dwell_q <= dwell_d;
    end
  end

  assign dec_out_o   = dec_q;
  assign code_out_o  = code_q;
  assign out_valid_o = vld_q;
  assign wrap_o      = wrap_q;
  assign range_err_o = rerr_q;

endmodule
